// File: rtl/sr_latch_sync.sv
// sr_latch_sync
//   Bank of WIDTH independent clocked set/reset bits. It replaces a
//   cross-coupled NOR SR latch in fully synchronous logic. The forbidden
//   S=R=1 input has a defined resolution and is reported on error outputs.
//
// Parameters
//   WIDTH       number of independent SR bits
//   INIT        value loaded into Q on reset
//   BOTH_POLICY resolution of S=R=1:
//               0 = hold, 1 = set-dominant, 2 or above = reset-dominant
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high, has priority over S/R
//   S, R       per-bit set / reset requests, sampled on the rising edge
//   Q          stored state (registered)
//   Qbar       bitwise complement of Q
//   both_err   per-bit pulse, high for the cycle after S=R=1 was sampled
//   err_sticky high once any both_err event has occurred, cleared by rst
module sr_latch_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int               BOTH_POLICY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] both_err,
  output logic             err_sticky
);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] both;

  assign both = S & R;

  always_comb begin
    q_next = Q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({S[i], R[i]})
        2'b10:   q_next[i] = 1'b1;
        2'b01:   q_next[i] = 1'b0;
        2'b11: begin
          if (BOTH_POLICY == 0)      q_next[i] = Q[i];
          else if (BOTH_POLICY == 1) q_next[i] = 1'b1;
          else                       q_next[i] = 1'b0;
        end
        default: q_next[i] = Q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q          <= INIT;
      both_err   <= '0;
      err_sticky <= 1'b0;
    end else begin
      Q          <= q_next;
      both_err   <= both;
      err_sticky <= err_sticky | (|both);
    end
  end

  // Derived from Q rather than a second register so Q and Qbar can
  // never disagree, even transiently.
  assign Qbar = ~Q;

endmodule

// File: tb/tb_sr_latch_sync.sv
module tb_sr_latch_sync;

  localparam int NI = 4;
  localparam int POL [NI] = '{0, 1, 2, 3};
  localparam logic [3:0] INITS [NI] = '{4'h0, 4'hA, 4'h5, 4'hF};

  logic clk = 1'b0;
  logic rst;
  logic [3:0] s, r;
  logic [3:0] dq [NI];
  logic [3:0] dqb [NI];
  logic [3:0] dbe [NI];
  logic       dst [NI];

  always #5 clk = ~clk;

  sr_latch_sync #(.WIDTH(4), .INIT(4'h0), .BOTH_POLICY(0)) u0 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(dq[0]), .Qbar(dqb[0]),
    .both_err(dbe[0]), .err_sticky(dst[0]));
  sr_latch_sync #(.WIDTH(4), .INIT(4'hA), .BOTH_POLICY(1)) u1 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(dq[1]), .Qbar(dqb[1]),
    .both_err(dbe[1]), .err_sticky(dst[1]));
  sr_latch_sync #(.WIDTH(4), .INIT(4'h5), .BOTH_POLICY(2)) u2 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(dq[2]), .Qbar(dqb[2]),
    .both_err(dbe[2]), .err_sticky(dst[2]));
  sr_latch_sync #(.WIDTH(4), .INIT(4'hF), .BOTH_POLICY(3)) u3 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(dq[3]), .Qbar(dqb[3]),
    .both_err(dbe[3]), .err_sticky(dst[3]));

  typedef struct packed {
    logic [NI-1:0][3:0] q;
    logic [NI-1:0][3:0] be;
    logic [NI-1:0]      st;
  } exp_t;

  exp_t sb [$];

  // reference state
  logic [3:0] mq [NI];
  logic       mst [NI];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int inst, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, inst, $time, act, exp);
    end
  endtask

  // Drive one input set and push the response expected after the next edge.
  task automatic drive(input logic rr, input logic [3:0] ss, input logic [3:0] rs);
    exp_t e;
    logic [3:0] both, keep;
    rst = rr; s = ss; r = rs;
    both = ss & rs;
    for (int k = 0; k < NI; k++) begin
      if (rr) begin
        mq[k]  = INITS[k];
        mst[k] = 1'b0;
        e.be[k] = 4'h0;
      end else begin
        // contested bits: hold, force 1, or force 0 depending on policy
        if (POL[k] == 0)      keep = mq[k] & both;
        else if (POL[k] == 1) keep = both;
        else                  keep = 4'h0;
        mq[k]  = (mq[k] & ~(ss | rs)) | (ss & ~rs) | keep;
        mst[k] = mst[k] | (both != 4'h0);
        e.be[k] = both;
      end
      e.q[k]  = mq[k];
      e.st[k] = mst[k];
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic rr, input logic [3:0] ss, input logic [3:0] rs);
    @(negedge clk);
    drive(rr, ss, rs);
  endtask

  // monitor: every edge the DUT presents a new output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < NI; k++) begin
          chk("q", k, dq[k], e.q[k]);
          chk("qbar", k, dqb[k], ~e.q[k]);
          chk("both_err", k, dbe[k], e.be[k]);
          chk("err_sticky", k, {3'b0, dst[k]}, {3'b0, e.st[k]});
        end
      end
    end
  end

  initial begin
    // reset with S=R=1 held: errors must stay clear
    drive(1'b1, 4'hF, 4'hF);
    repeat (3) step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h0);
    repeat (4) step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'hF);
    repeat (4) step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'hA, 4'h5);
    step(1'b0, 4'hF, 4'hF);
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'hF);
    step(1'b0, 4'hF, 4'hF);
    step(1'b0, 4'hF, 4'hF);
    repeat (2) step(1'b0, 4'h0, 4'h0);
    // reset with R held: INIT wins
    step(1'b1, 4'h0, 4'hF);
    step(1'b0, 4'hA, 4'h0);
    step(1'b0, 4'h5, 4'h3);
    step(1'b0, 4'h0, 4'h0);
    for (int n = 0; n < 400; n++)
      step(($urandom_range(15) == 0), 4'($urandom), 4'($urandom));
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
